md_unit_ctrl: RTL
=================

MD_UNIT_CTRL -- requirements
Module: md_unit_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL expose: reset  in  1  synchronous, active-low reset.
REQ-003 SHALL expose: start  in  1  E-stage mult/div/move instruction valid this cycle.
REQ-004 SHALL expose: md_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-ops.
REQ-005 SHALL expose: rs_val  in  32  operand A; the move source for MTHI/MTLO.
REQ-006 SHALL expose: rt_val  in  32  operand B.
REQ-007 SHALL expose: cancel  in  1  interrupt/exception flush (IntReq_W) aborting the current E-stage start and any in-flight operation.
REQ-008 SHALL expose: d_is_md  in  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
REQ-009 SHALL expose: busy  out  1  multi-cycle operation in flight.
REQ-010 SHALL expose: md_stall  out  1  freeze D stage.
REQ-011 SHALL expose: hi  out  32  architectural HI.
REQ-012 SHALL expose: lo  out  32  architectural LO.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, with a 4-bit cycle counter.
REQ-014 IDLE: start & ~cancel & md_op MULT/MULTU SHALL latch the 64-bit product (signed or unsigned) into pending registers, load counter = 5, and enter MUL.
REQ-015 IDLE: start & ~cancel & md_op DIV/DIVU SHALL latch quotient/remainder (signed or unsigned) into pending registers, load counter = 10, and enter DIV.
REQ-016 Signed DIV SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-017 MUL/DIV: counter SHALL decrement each cycle; on the edge where counter == 1, hi/lo SHALL take the pending values and the FSM SHALL return to IDLE.
REQ-018 busy SHALL be 1 exactly in MUL/DIV: 5 cycles for mult, 10 for div, starting the cycle after start; new hi/lo SHALL be visible in the first cycle busy is 0.
REQ-019 MUL result SHALL be hi = product[63:32], lo = product[31:0].
REQ-020 DIV result SHALL be lo = quotient, hi = remainder.
REQ-021 Divide by zero (rt_val == 0) SHALL still run 10 cycles and SHALL leave hi/lo unchanged.
REQ-022 MTHI/MTLO with start & ~cancel in IDLE SHALL write rs_val to hi/lo at the next edge, SHALL NOT assert busy, and SHALL leave the other register unchanged.
REQ-023 start while busy SHALL be ignored; the pipeline guarantees this case via md_stall.
REQ-024 cancel in MUL/DIV SHALL return the FSM to IDLE at the next edge, discard the pending result, and leave hi/lo at pre-operation values.
REQ-025 cancel together with start SHALL suppress the start, including MTHI/MTLO writes.
REQ-026 md_stall SHALL equal d_is_md & (busy | (start & ~cancel & md_op in MULT/MULTU/DIV/DIVU)), and SHALL be combinational.
REQ-027 Undefined md_op values with start SHALL change no state.

Reset
REQ-028 reset == 0 at a clock edge SHALL force IDLE, counter = 0, hi = 0, lo = 0, pending = 0, busy = 0.
REQ-029 Reset SHALL override start and cancel, including mid-operation; the in-flight result SHALL be lost.
REQ-030 md_stall SHALL be 0 in the cycle after reset when start = 0.

Structure
REQ-031 md_op encodings, latency constants (MUL_LAT = 5, DIV_LAT = 10) and FSM state encodings SHALL live in the shared header alongside the opcode/funct defines.
REQ-032 The block SHALL be a single module with no sub-modules; the arithmetic SHALL be behavioural *, / and % on 32-bit operands, and the latency SHALL come from the counter.

Verification
REQ-033 MULT rs = 0xFFFFFFFE (-2), rt = 3 -> busy high 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA.
REQ-034 MULTU rs = 0xFFFFFFFF, rt = 2 -> hi = 0x00000001, lo = 0xFFFFFFFE after 5 busy cycles.
REQ-035 DIV rs = -7, rt = 2 -> busy 10 cycles, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 7/0 -> 10 busy cycles, hi/lo unchanged.
REQ-036 DIV started, d_is_md = 1 from cycle 0 -> md_stall = 1 for cycles 0..10, 0 when busy falls.
REQ-037 MULT in flight, cancel at busy cycle 3 -> busy = 0 next cycle, hi/lo hold prior MTHI 0x12345678 / MTLO 0x9ABCDEF0 values.
REQ-038 reset low at div busy cycle 4 -> next cycle busy = 0, hi = lo = 0; start with cancel = 1 -> no state change.

Source files
------------

// File: rtl/md_unit_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl_pkg
// Shared definitions for the multiply/divide unit controller:
//   - md_op encodings driven by the E-stage decoder
//   - MIPS opcode/funct values for the HI/LO instruction group
//   - multi-cycle latencies (the counter load values)
//   - FSM state encoding
//   - small decode helpers used by the controller
// -----------------------------------------------------------------------------
package md_unit_ctrl_pkg;

   // md_op encodings; the values 110 and 111 are deliberately undefined
   // and must behave as no-ops.
   localparam logic [2:0] MD_OP_MULT  = 3'b000;
   localparam logic [2:0] MD_OP_MULTU = 3'b001;
   localparam logic [2:0] MD_OP_DIV   = 3'b010;
   localparam logic [2:0] MD_OP_DIVU  = 3'b011;
   localparam logic [2:0] MD_OP_MTHI  = 3'b100;
   localparam logic [2:0] MD_OP_MTLO  = 3'b101;

   // MIPS SPECIAL-opcode funct fields for the HI/LO group, kept next to the
   // md_op encodings so the decoder and this unit share one source of truth.
   localparam logic [5:0] OPCODE_SPECIAL = 6'h00;
   localparam logic [5:0] FUNCT_MFHI     = 6'h10;
   localparam logic [5:0] FUNCT_MTHI     = 6'h11;
   localparam logic [5:0] FUNCT_MFLO     = 6'h12;
   localparam logic [5:0] FUNCT_MTLO     = 6'h13;
   localparam logic [5:0] FUNCT_MULT     = 6'h18;
   localparam logic [5:0] FUNCT_MULTU    = 6'h19;
   localparam logic [5:0] FUNCT_DIV      = 6'h1a;
   localparam logic [5:0] FUNCT_DIVU     = 6'h1b;

   // Number of busy cycles seen by the pipeline for each operation class.
   localparam logic [3:0] MUL_LAT = 4'd5;
   localparam logic [3:0] DIV_LAT = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } md_state_e;

   // True for the operations that occupy the unit for several cycles.
   function automatic logic is_multicycle(input logic [2:0] op);
      return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
             (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
   endfunction

   // True for a divide whose divisor is non-zero (only those update HI/LO).
   function automatic logic divisor_ok(input logic [31:0] divisor);
      return divisor != 32'd0;
   endfunction

endpackage

// File: rtl/md_unit_ctrl.sv
// -----------------------------------------------------------------------------
// md_unit_ctrl
// Multiply/divide unit controller for a 5-stage MIPS-style pipeline. The
// arithmetic result is computed in one shot when the operation starts and is
// parked in pending registers; a down-counter then models the unit latency
// and HI/LO are only committed when the counter expires. A flush (cancel) or
// reset during that window simply drops the pending result.
//
// Ports
//   clk      in   1  clock, all state updates on the rising edge
//   reset    in   1  synchronous active-low reset
//   start    in   1  E-stage mult/div/move instruction valid
//   md_op    in   3  operation select (see md_unit_ctrl_pkg)
//   rs_val   in  32  operand A / move source for MTHI, MTLO
//   rt_val   in  32  operand B
//   cancel   in   1  flush: suppresses start, aborts an in-flight operation
//   d_is_md  in   1  D-stage instruction uses the HI/LO unit
//   busy     out  1  multi-cycle operation in flight
//   md_stall out  1  freeze D stage (combinational)
//   hi       out 32  architectural HI
//   lo       out 32  architectural LO
// -----------------------------------------------------------------------------
module md_unit_ctrl
   import md_unit_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        cancel,
   input  logic        d_is_md,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   // Set when the pending pair must be committed on completion; cleared for
   // divide-by-zero so HI/LO survive untouched.
   logic        pend_we_q, pend_we_d;

   logic        go;
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] quo_s, rem_s;
   logic [31:0] quo_u, rem_u;
   logic        div_ok;

   // ---------------------------------------------------------------------
   // Datapath: behavioural arithmetic on the E-stage operands.
   // Operands are widened explicitly so the products are full 64-bit.
   // ---------------------------------------------------------------------
   always_comb begin
      prod_s = $signed({{32{rs_val[31]}}, rs_val}) *
               $signed({{32{rt_val[31]}}, rt_val});
      prod_u = {32'd0, rs_val} * {32'd0, rt_val};
      div_ok = divisor_ok(rt_val);
      quo_s  = '0;
      rem_s  = '0;
      quo_u  = '0;
      rem_u  = '0;
      // Guarding the divide keeps X's out of the pending registers when the
      // divisor is zero. Signed / and % truncate toward zero, which gives the
      // remainder the sign of the dividend.
      if (div_ok) begin
         quo_s = $signed(rs_val) / $signed(rt_val);
         rem_s = $signed(rs_val) % $signed(rt_val);
         quo_u = rs_val / rt_val;
         rem_u = rs_val % rt_val;
      end
   end

   assign go = start & ~cancel;

   // ---------------------------------------------------------------------
   // Next-state and register-update logic.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_we_d = pend_we_q;

      unique case (state_q)
         ST_IDLE: begin
            if (go) begin
               case (md_op)
                  MD_OP_MULT: begin
                     pend_hi_d = prod_s[63:32];
                     pend_lo_d = prod_s[31:0];
                     pend_we_d = 1'b1;
                     cnt_d     = MUL_LAT;
                     state_d   = ST_MUL;
                  end
                  MD_OP_MULTU: begin
                     pend_hi_d = prod_u[63:32];
                     pend_lo_d = prod_u[31:0];
                     pend_we_d = 1'b1;
                     cnt_d     = MUL_LAT;
                     state_d   = ST_MUL;
                  end
                  MD_OP_DIV: begin
                     pend_hi_d = rem_s;
                     pend_lo_d = quo_s;
                     pend_we_d = div_ok;
                     cnt_d     = DIV_LAT;
                     state_d   = ST_DIV;
                  end
                  MD_OP_DIVU: begin
                     pend_hi_d = rem_u;
                     pend_lo_d = quo_u;
                     pend_we_d = div_ok;
                     cnt_d     = DIV_LAT;
                     state_d   = ST_DIV;
                  end
                  MD_OP_MTHI: hi_d = rs_val;
                  MD_OP_MTLO: lo_d = rs_val;
                  default: ; // undefined encodings leave all state alone
               endcase
            end
         end

         ST_MUL, ST_DIV: begin
            // start is ignored here; the pipeline holds D via md_stall.
            if (cancel) begin
               // Flush wins over a same-cycle completion: the result is lost.
               state_d   = ST_IDLE;
               cnt_d     = '0;
               pend_hi_d = '0;
               pend_lo_d = '0;
               pend_we_d = 1'b0;
            end else begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  if (pend_we_q) begin
                     hi_d = pend_hi_q;
                     lo_d = pend_lo_q;
                  end
                  pend_we_d = 1'b0;
                  state_d   = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_we_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_we_q <= pend_we_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign busy = (state_q != ST_IDLE);
   // The D stage must also freeze in the very cycle a multi-cycle op is
   // accepted, before busy has had a chance to rise.
   assign md_stall = d_is_md & (busy | (go & is_multicycle(md_op)));
   assign hi = hi_q;
   assign lo = lo_q;

endmodule
